// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Whole system clocks per serial bit; fractional remainder is dropped.
  function automatic int clocks_per_bit(input int clk_speed, input int baud_rate);
    return clk_speed / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing an end-of-bit pulse
module uart_baud_gen #(
  parameter int BAUD_TICK = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_TICK - 1);

  logic [CNT_W-1:0] count;

  assign bit_end = (count == LAST);

  // Count 0..BAUD_TICK-1, wrapping on each bit boundary; clear forces a fresh bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - 8-N-1 UART transmitter with one-deep holding register
module uart_transmit
  import uart_pkg::*;
#(
  parameter int CLK_SPEED = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_TICK = clocks_per_bit(CLK_SPEED, BAUD_RATE);
  localparam int IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  if (BAUD_TICK < 2) begin : g_bad_tick
    $error("uart_transmit: CLK_SPEED/BAUD_RATE must give at least 2 clocks per bit");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_transmit: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state, state_next;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;

  logic bit_end;
  logic accept;
  logic load;
  logic shift_step;
  logic stop_step;
  logic frame_end;
  logic baud_clear;
  logic last_stop;

  // ready is the inverse of a flop, so it never depends on this cycle's send.
  assign ready      = ~hold_full;
  assign accept     = send && ready;
  assign last_stop  = (STOP_BITS == 1) || stop_cnt;
  assign baud_clear = (state == IDLE) || load;

  uart_baud_gen #(
    .BAUD_TICK(BAUD_TICK)
  ) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes; a waiting byte is launched straight from the last stop clock.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_step = 1'b0;
    stop_step  = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_step = 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            frame_end = 1'b1;
            if (hold_full) begin
              load       = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_step = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register: filled by the producer, emptied when the shifter takes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= data_in;
    end
  end

  // Shift register, data bit index and stop-bit counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      if (load) begin
        shift_reg <= hold_data;
        bit_idx   <= '0;
      end else if (shift_step) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + IDX_W'(1);
      end
      if (load || frame_end) begin
        stop_cnt <= 1'b0;
      end else if (stop_step) begin
        stop_cnt <= 1'b1;
      end
    end
  end

  // Registered line outputs; they trail the state by one clock so tx, busy and done stay aligned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        default: tx <= 1'b1;
      endcase
      busy <= (state != IDLE);
      done <= frame_end;
    end
  end

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - randomized self-checking bench for uart_transmit
module tb_uart_transmit;

  localparam int BT   = 10;
  localparam int MAXE = 4096;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] data_a, data_b;
  logic       send_a, send_b;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  always #5 clock = ~clock;

  uart_transmit #(.CLK_SPEED(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .data_in(data_a), .send(send_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  uart_transmit #(.CLK_SPEED(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .data_in(data_b), .send(send_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  int n_cmp = 0;
  int n_bad = 0;

  int ecount = 0;
  always @(posedge clock) ecount <= ecount + 1;

  // Trace of {tx,busy,done,ready} after each rising edge, relative to base.
  logic [3:0] tr[MAXE];
  logic [3:0] ex[MAXE];
  int base;
  int n_win;
  bit rec = 1'b0;
  int rec_sel = 0;
  int ridx;

  always @(negedge clock) begin
    if (rec) begin
      ridx = ecount - base;
      if (ridx >= 0 && ridx < MAXE)
        tr[ridx] = (rec_sel == 0) ? {tx_a, busy_a, done_a, ready_a} : {tx_b, busy_b, done_b, ready_b};
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input int which, input logic s, input logic [7:0] d);
    if (which == 0) begin send_a = s; data_a = d; end
    else begin send_b = s; data_b = d; end
  endtask

  // Drive bytes with the given idle gaps, record the trace, and build the expected trace
  // from frame arithmetic: a frame starts at max(accept+2, previous end+1) and lasts
  // (9+stop bits)*BT clocks; ready is low from the accept edge until two before launch.
  task automatic run_frames(input int which, input int sb, input logic [7:0] bytes[$], input int gaps[$]);
    int acc[$];
    int s, prev_end, len, k, t;
    logic rdy;
    @(negedge clock);
    base = ecount + 1;
    rec_sel = which;
    rec = 1'b1;
    for (int i = 0; i < bytes.size(); i++) begin
      repeat (gaps[i]) begin
        @(negedge clock);
        set_in(which, 1'b0, 8'($urandom));
      end
      @(negedge clock);
      set_in(which, 1'b1, bytes[i]);
      t = 0;
      rdy = (which == 0) ? ready_a : ready_b;
      while (!rdy && t < 400) begin
        @(negedge clock);
        t++;
        rdy = (which == 0) ? ready_a : ready_b;
      end
      if (!rdy) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout byte %0d: ready stayed %b, required 1", i, rdy);
      end
      acc.push_back(ecount + 1 - base);
    end
    @(negedge clock);
    set_in(which, 1'b0, 8'($urandom));

    for (int e = 0; e < MAXE; e++) ex[e] = 4'b1001;
    prev_end = -1;
    len = (9 + sb) * BT;
    for (int i = 0; i < bytes.size(); i++) begin
      s = (acc[i] + 2 > prev_end + 1) ? acc[i] + 2 : prev_end + 1;
      for (int e = acc[i]; e <= s - 2; e++) if (e >= 0 && e < MAXE) ex[e][0] = 1'b0;
      for (int e = s; e < s + len && e < MAXE; e++) begin
        k = (e - s) / BT;
        ex[e][3] = (k == 0) ? 1'b0 : (k <= 8) ? bytes[i][k-1] : 1'b1;
        ex[e][2] = 1'b1;
        ex[e][1] = (e == s + len - 1);
      end
      prev_end = s + len - 1;
    end
    n_win = (prev_end + 30 < MAXE) ? prev_end + 30 : MAXE;
    t = 0;
    while (ecount < base + n_win && t < MAXE + 10) begin
      @(negedge clock);
      t++;
    end
    rec = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] q[$];
    int gaps[$];
    @(negedge clock);
    set_in(0, 1'b1, 8'hC3);
    repeat (30) @(negedge clock);
    set_in(0, 1'b0, 8'h00);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({tx_a, busy_a, done_a, ready_a} !== 4'b1001) begin
        n_bad++;
        $display("FAIL reset_idle_a clk %0d {tx,busy,done,ready}: got %b expected 1001", i, {tx_a, busy_a, done_a, ready_a});
      end
      n_cmp++;
      if ({tx_b, busy_b, done_b, ready_b} !== 4'b1001) begin
        n_bad++;
        $display("FAIL reset_idle_b clk %0d {tx,busy,done,ready}: got %b expected 1001", i, {tx_b, busy_b, done_b, ready_b});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] q[$];
    int gaps[$];
    int shown = 0, n_done = 0, n_busy = 0, first_busy = -1, done_at = -1;
    q.push_back(8'hA5); gaps.push_back(3);
    run_frames(0, 1, q, gaps);
    for (int e = 0; e < n_win; e++) begin
      n_cmp++;
      if (tr[e] !== ex[e]) begin
        n_bad++;
        if (shown++ < 4) $display("FAIL single_a5 edge %0d {tx,busy,done,ready}: got %b expected %b", e, tr[e], ex[e]);
      end
      if (tr[e][2]) begin n_busy++; if (first_busy < 0) first_busy = e; end
      if (tr[e][1]) begin n_done++; done_at = e; end
    end
    n_cmp++;
    if (n_done !== 1) begin n_bad++; $display("FAIL single_done_count: got %0d required 1", n_done); end
    n_cmp++;
    if (n_busy !== 100) begin n_bad++; $display("FAIL single_busy_len: got %0d required 100", n_busy); end
    n_cmp++;
    if (done_at - first_busy !== 99) begin
      n_bad++; $display("FAIL single_done_pos: got clock %0d required 100", done_at - first_busy + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int gaps[$];
    int shown = 0, n_busy = 0, d0 = -1, d1 = -1;
    q.push_back(8'h00); q.push_back(8'hFF);
    gaps.push_back(2); gaps.push_back(0);
    run_frames(0, 1, q, gaps);
    for (int e = 0; e < n_win; e++) begin
      n_cmp++;
      if (tr[e] !== ex[e]) begin
        n_bad++;
        if (shown++ < 4) $display("FAIL back_to_back edge %0d {tx,busy,done,ready}: got %b expected %b", e, tr[e], ex[e]);
      end
      if (tr[e][2]) n_busy++;
      if (tr[e][1]) begin if (d0 < 0) d0 = e; else d1 = e; end
    end
    n_cmp++;
    if (n_busy !== 200) begin n_bad++; $display("FAIL b2b_busy_len: got %0d required 200", n_busy); end
    n_cmp++;
    if (d1 - d0 !== 100) begin n_bad++; $display("FAIL b2b_done_spacing: got %0d required 100", d1 - d0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    int gaps[$];
    int shown = 0;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    gaps.push_back(1); gaps.push_back(0); gaps.push_back(0);
    run_frames(0, 1, q, gaps);
    for (int e = 0; e < n_win; e++) begin
      n_cmp++;
      if (tr[e] !== ex[e]) begin
        n_bad++;
        if (shown++ < 4) $display("FAIL backpressure edge %0d {tx,busy,done,ready}: got %b expected %b", e, tr[e], ex[e]);
      end
    end
  endtask

  task automatic test_two_stop();
    logic [7:0] q[$];
    int gaps[$];
    int shown = 0, n_busy = 0;
    q.push_back(8'h80); gaps.push_back(2);
    run_frames(1, 2, q, gaps);
    for (int e = 0; e < n_win; e++) begin
      n_cmp++;
      if (tr[e] !== ex[e]) begin
        n_bad++;
        if (shown++ < 4) $display("FAIL two_stop edge %0d {tx,busy,done,ready}: got %b expected %b", e, tr[e], ex[e]);
      end
      if (tr[e][2]) n_busy++;
    end
    n_cmp++;
    if (n_busy !== 110) begin n_bad++; $display("FAIL two_stop_len: got %0d required 110", n_busy); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] q[$];
    int gaps[$];
    int acc, t, shown = 0;
    @(negedge clock);
    set_in(0, 1'b1, 8'h5A);
    acc = ecount + 1;
    @(negedge clock);
    set_in(0, 1'b0, 8'h00);
    t = 0;
    while (ecount < acc + 2 + 44 && t < 200) begin @(negedge clock); t++; end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_a, busy_a, done_a, ready_a} !== 4'b1001) begin
      n_bad++;
      $display("FAIL midframe_async {tx,busy,done,ready}: got %b expected 1001", {tx_a, busy_a, done_a, ready_a});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({tx_a, done_a} !== 2'b10) begin
        n_bad++; $display("FAIL midframe_held {tx,done}: got %b expected 10", {tx_a, done_a});
      end
    end
    reset_n = 1'b1;
    q.push_back(8'h3C); gaps.push_back(2);
    run_frames(0, 1, q, gaps);
    for (int e = 0; e < n_win; e++) begin
      n_cmp++;
      if (tr[e] !== ex[e]) begin
        n_bad++;
        if (shown++ < 4) $display("FAIL midframe_restart edge %0d {tx,busy,done,ready}: got %b expected %b", e, tr[e], ex[e]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int gaps[$];
    int shown = 0;
    for (int i = 0; i < 6; i++) begin
      q.push_back(8'($urandom));
      gaps.push_back(int'($urandom_range(0, 120)));
    end
    run_frames(0, 1, q, gaps);
    for (int e = 0; e < n_win; e++) begin
      n_cmp++;
      if (tr[e] !== ex[e]) begin
        n_bad++;
        if (shown++ < 4) $display("FAIL random_1stop edge %0d {tx,busy,done,ready}: got %b expected %b", e, tr[e], ex[e]);
      end
    end
    q.delete(); gaps.delete(); shown = 0;
    for (int i = 0; i < 3; i++) begin
      q.push_back(8'($urandom));
      gaps.push_back(int'($urandom_range(0, 60)));
    end
    run_frames(1, 2, q, gaps);
    for (int e = 0; e < n_win; e++) begin
      n_cmp++;
      if (tr[e] !== ex[e]) begin
        n_bad++;
        if (shown++ < 4) $display("FAIL random_2stop edge %0d {tx,busy,done,ready}: got %b expected %b", e, tr[e], ex[e]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    send_a = 1'b0; data_a = 8'h00;
    send_b = 1'b0; data_b = 8'h00;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_two_stop();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
